// File: rtl/sd_mod2_tx.sv
// Second-order delta-sigma modulator: signed parallel samples in, one bit per
// clock out, fed through a one-entry buffer that is drained at frame boundaries.
module sd_mod2_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int OSR_WIDTH  = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4,
  parameter int LIMIT      = 3 * 2**(DATA_WIDTH-3)
) (
  input  logic                         clock,
  input  logic                         aclr,
  input  logic                         run,
  input  logic [OSR_WIDTH-1:0]         osr,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic                         valid,
  output logic                         ready,
  input  logic                         clr_underrun,
  output logic                         sdo,
  output logic                         frame,
  output logic                         underrun
);

  // Two guard bits above the integrator width keep every sum exact before saturation.
  localparam int EXT = ACC_WIDTH + 2;
  localparam logic signed [EXT-1:0] FS_E  = EXT'(2**(DATA_WIDTH-1));
  localparam logic signed [EXT-1:0] LIM_E = EXT'(LIMIT);
  localparam logic signed [EXT-1:0] MAX_E = EXT'(2**(ACC_WIDTH-1) - 1);

  logic [OSR_WIDTH-1:0]         cnt;
  logic [OSR_WIDTH-1:0]         osr_reg;
  logic signed [DATA_WIDTH-1:0] buf_q;
  logic signed [DATA_WIDTH-1:0] hold;
  logic                         buf_full;
  logic signed [ACC_WIDTH-1:0]  i1;
  logic signed [ACC_WIDTH-1:0]  i2;

  logic                         hit;
  logic                         xfer;
  logic signed [EXT-1:0]        hold_e;
  logic signed [EXT-1:0]        x;
  logic signed [EXT-1:0]        fb;
  logic signed [EXT-1:0]        sum1;
  logic signed [EXT-1:0]        sum2;
  logic signed [ACC_WIDTH-1:0]  i1n;
  logic signed [ACC_WIDTH-1:0]  i2n;

  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [EXT-1:0] v);
    logic signed [EXT-1:0] r;
    if (v > MAX_E)       r = MAX_E;
    else if (v < -MAX_E) r = -MAX_E;
    else                 r = v;
    return r[ACC_WIDTH-1:0];
  endfunction

  assign hit   = (cnt == osr_reg) && run;
  assign ready = !buf_full || hit;
  assign xfer  = valid && ready;

  // NOTE: combinational block uses blocking assignments and gives every
  // variable a value on every path, so no latch can be inferred.
  always_comb begin
    hold_e = EXT'(hold);
    if (hold_e > LIM_E)       x = LIM_E;
    else if (hold_e < -LIM_E) x = -LIM_E;
    else                      x = hold_e;
    fb   = sdo ? FS_E : -FS_E;
    sum1 = EXT'(i1) + x - fb;
    i1n  = sat(sum1);
    sum2 = EXT'(i2) + EXT'(i1n) - fb;
    i2n  = sat(sum2);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      cnt     <= '0;
      osr_reg <= '0;
      frame   <= 1'b0;
    end else begin
      frame <= hit;
      if (!run) begin
        cnt <= '0;
      end else if (hit) begin
        cnt     <= '0;
        osr_reg <= osr;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Buffer refills in the same cycle it is drained, so a steady source never underruns.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      hold     <= '0;
      underrun <= 1'b0;
    end else begin
      if (xfer) buf_q <= data;
      if (hit && buf_full) begin
        hold     <= buf_q;
        buf_full <= xfer;
      end else if (xfer) begin
        buf_full <= 1'b1;
      end
      if (hit && !buf_full) underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

  // Idle (run=0) emits an alternating pattern so a downstream DAC sees zero mean.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      i1  <= '0;
      i2  <= '0;
      sdo <= 1'b0;
    end else if (!run) begin
      i1  <= '0;
      i2  <= '0;
      sdo <= !sdo;
    end else begin
      i1  <= i1n;
      i2  <= i2n;
      sdo <= !i2n[ACC_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_sd_mod2_tx.sv
// Bench for sd_mod2_tx: bitstream density against the ideal (1 + x/FS)/2,
// plus frame timing, handshake, underrun and reset behaviour.
module tb_sd_mod2_tx;
  localparam int DW    = 16;
  localparam int OW    = 8;
  localparam int FS    = 2**(DW-1);
  localparam int LIMIT = 3 * 2**(DW-3);
  localparam int WIN   = 1024;  // four 256-clock frames, tolerances scaled by 4

  logic                 clock = 1'b0;
  logic                 aclr;
  logic                 run;
  logic [OW-1:0]        osr;
  logic signed [DW-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 clr_underrun;
  logic                 sdo;
  logic                 frame;
  logic                 underrun;

  int n_cmp = 0;
  int n_bad = 0;

  sd_mod2_tx #(.DATA_WIDTH(DW), .OSR_WIDTH(OW)) dut (
    .clock(clock), .aclr(aclr), .run(run), .osr(osr), .data(data),
    .valid(valid), .ready(ready), .clr_underrun(clr_underrun),
    .sdo(sdo), .frame(frame), .underrun(underrun)
  );

  always #5 clock = ~clock;

  function automatic int clamp_ref(input int v);
    return (v > LIMIT) ? LIMIT : ((v < -LIMIT) ? -LIMIT : v);
  endfunction

  // Ideal count of ones over n clocks for a DC input v.
  function automatic int ones_ref(input int v, input int n);
    return (n * (FS + clamp_ref(v)) + FS) / (2 * FS);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (frame) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_period(input int budget, output int p);
    p = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      p++;
      if (frame) break;
    end
  endtask

  task automatic run_dc(input string name, input int value, input int tol);
    bit ok;
    int ones, run_len, max_run, expv, diff;
    data  = DW'(value);
    valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_frame(600, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_settle: no frame pulse within 600 clocks", name);
        return;
      end
    end
    clr_underrun = 1'b1;
    step(1);
    clr_underrun = 1'b0;
    ones = 0; run_len = 0; max_run = 0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clock);
      if (sdo) begin
        ones++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
    expv = ones_ref(value, WIN);
    diff = (ones > expv) ? ones - expv : expv - ones;
    n_cmp++;
    if (diff > 4 * tol) begin
      n_bad++;
      $display("FAIL %s_density: input %0d got %0d ones/%0d clocks, want %0d +/- %0d",
               name, value, ones, WIN, expv, 4 * tol);
    end
    n_cmp++;
    if (max_run > 16) begin
      n_bad++;
      $display("FAIL %s_ones_run: longest run of ones %0d, want <= 16", name, max_run);
    end
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_underrun: got %b want 0", name, underrun);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1; run = 1'b0; valid = 1'b0; clr_underrun = 1'b0; osr = 8'd255; data = '0;
    step(2);
    aclr = 1'b0; run = 1'b1;
    step(1);
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_underrun: got %b want 1", underrun);
    end
    valid = 1'b1; data = 16'sd100;
    step(10);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset_ready_full: got %b want 0", ready);
    end
    #2 aclr = 1'b1; run = 1'b0;
    #1;
    n_cmp++;
    if ({sdo, ready, underrun, frame} !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_outputs: sdo/ready/underrun/frame got %b want 0100",
               {sdo, ready, underrun, frame});
    end
    n_cmp++;
    if (dut.i1 !== '0 || dut.i2 !== '0) begin
      n_bad++;
      $display("FAIL reset_integrators: i1 %0d i2 %0d want 0 0", dut.i1, dut.i2);
    end
    step(1);
    aclr = 1'b0;
  endtask

  task automatic test_dc_zero();
    run_dc("dc_zero", 0, 2);
  endtask

  task automatic test_dc_half();
    run_dc("dc_pos_half", 16384, 3);
    run_dc("dc_neg_half", -16384, 3);
  endtask

  task automatic test_clamp();
    run_dc("clamp_max", 32767, 3);
  endtask

  task automatic test_dc_random();
    int v;
    for (int r = 0; r < 3; r++) begin
      v = int'($urandom_range(0, 2 * (LIMIT + 6000))) - (LIMIT + 6000);
      run_dc("dc_random", v, 3);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic signed [DW-1:0] a;
    a = DW'(int'($urandom_range(0, 2 * LIMIT)) - LIMIT);
    wait_frame(600, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL underrun_sync: no frame pulse within 600 clocks");
      return;
    end
    data = a; valid = 1'b1;
    step(254);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_before_hit: got %b want 0", ready);
    end
    step(1);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_on_hit: got %b want 1", ready);
    end
    step(1);
    valid = 1'b0;
    n_cmp++;
    if (frame !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_after_hit: got %b want 1", frame);
    end
    step(256);
    n_cmp++;
    if (dut.hold !== a || ready !== 1'b1 || underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_loaded: hold %0d ready %b underrun %b want %0d 1 0",
               dut.hold, ready, underrun, a);
    end
    step(255);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_early: got %b want 0", underrun);
    end
    step(1);
    n_cmp++;
    if (underrun !== 1'b1 || dut.hold !== a) begin
      n_bad++;
      $display("FAIL underrun_set: underrun %b hold %0d want 1 %0d", underrun, dut.hold, a);
    end
    step(255);
    clr_underrun = 1'b1;
    step(1);
    clr_underrun = 1'b0;
    n_cmp++;
    if (underrun !== 1'b1 || dut.hold !== a) begin
      n_bad++;
      $display("FAIL underrun_set_wins: underrun %b hold %0d want 1 %0d", underrun, dut.hold, a);
    end
    clr_underrun = 1'b1;
    step(1);
    clr_underrun = 1'b0;
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_osr_change();
    bit ok;
    int p;
    data = '0; valid = 1'b1;
    wait_frame(600, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL osr_sync: no frame pulse within 600 clocks");
      return;
    end
    step(100);
    osr = 8'd15;
    measure_period(600, p);
    n_cmp++;
    if (p + 100 !== 256) begin
      n_bad++;
      $display("FAIL osr_current_frame: period %0d want 256", p + 100);
    end
    for (int f = 0; f < 2; f++) begin
      measure_period(600, p);
      n_cmp++;
      if (p !== 16) begin
        n_bad++;
        $display("FAIL osr_new_frame: period %0d want 16", p);
      end
    end
  endtask

  task automatic test_run_idle();
    logic prev;
    int p;
    run = 1'b0;
    step(1);
    n_cmp++;
    if (frame !== 1'b0 || dut.i1 !== '0 || dut.i2 !== '0) begin
      n_bad++;
      $display("FAIL idle_state: frame %b i1 %0d i2 %0d want 0 0 0", frame, dut.i1, dut.i2);
    end
    prev = sdo;
    for (int k = 0; k < 8; k++) begin
      step(1);
      n_cmp++;
      if (sdo !== ~prev) begin
        n_bad++;
        $display("FAIL idle_toggle: sdo %b want %b", sdo, ~prev);
      end
      prev = sdo;
    end
    run = 1'b1;
    measure_period(600, p);
    n_cmp++;
    if (p !== 16) begin
      n_bad++;
      $display("FAIL run_restart_first_hit: %0d clocks want 16", p);
    end
  endtask

  task automatic test_osr_zero();
    bit ok;
    osr = '0;
    wait_frame(600, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL osr0_sync: no frame pulse within 600 clocks");
      return;
    end
    step(1);
    for (int k = 0; k < 6; k++) begin
      step(1);
      n_cmp++;
      if (frame !== 1'b1) begin
        n_bad++;
        $display("FAIL osr0_frame: got %b want 1 every clock", frame);
      end
    end
  endtask

  initial begin
    aclr = 1'b1; run = 1'b0; valid = 1'b0; clr_underrun = 1'b0; osr = '0; data = '0;
    test_reset();
    osr = 8'd255;
    run = 1'b1;
    test_dc_zero();
    test_dc_half();
    test_clamp();
    test_dc_random();
    test_underrun();
    test_osr_change();
    test_run_idle();
    test_osr_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_mod2_tx.md
Name: sd_mod2_tx

Overview:
- Second-order digital delta-sigma modulator that turns parallel signed samples into a 1-bit stream, one bit per clock.
- It is the transmit-side counterpart of the sinc3 bitstream decimator and can drive a 1-bit DAC/driver or loop back into the decimator.
- A programmable oversampling frame sets how often a new sample is consumed.
- Input uses a valid/ready handshake with a one-entry buffer; frame boundaries come from a counter with the same "OSR minus 1" semantics as the receive side.

Parameters:
- DATA_WIDTH, 16: signed input sample width. FS = 2**(DATA_WIDTH-1).
- OSR_WIDTH, 8: width of the osr port and frame counter. Frame length = osr+1 clocks.
- ACC_WIDTH, DATA_WIDTH+4: width of the signed integrators.
- LIMIT, 3*2**(DATA_WIDTH-3): input clamp magnitude (0.75 FS), which keeps the loop stable.

Ports:
- clock  in  1  system clock
- aclr  in  1  asynchronous active-high reset
- run  in  1  modulator enable
- osr  in  OSR_WIDTH  frame length minus 1; sampled at frame boundary
- data  in  DATA_WIDTH  signed input sample
- valid  in  1  data valid
- ready  out  1  buffer can accept data
- clr_underrun  in  1  clears the underrun flag
- sdo  out  1  bitstream; 1 = +FS, 0 = -FS
- frame  out  1  one-cycle pulse at frame boundary
- underrun  out  1  sticky: no sample was available at a frame boundary

Behaviour:
- Reset (aclr=1, any time, asynchronous): i1=i2=0, cnt=0, osr_reg=0, buffer empty, hold=0, sdo=0, frame=0, underrun=0. Consequently ready=1 after reset.
- Frame counter (counts only when run=1):
  - hit = (cnt==osr_reg) & run.
  - On hit: cnt<=0 and osr_reg<=osr. Otherwise cnt<=cnt+1.
  - frame<=hit, registered, so frame is high the cycle after hit.
  - A change on osr takes effect only after the next boundary. osr=0 gives a frame length of 1.
- Input buffer:
  - ready = ~buf_full | hit.
  - A transfer happens when valid&ready. It writes buf and sets buf_full.
  - On hit with buf_full: hold<=buf, and buf_full clears unless a transfer occurs in the same cycle, in which case buf takes the new data and stays full.
  - On hit with the buffer empty: hold is kept and underrun<=1. There is no bypass: a same-cycle transfer only fills buf.
  - clr_underrun clears the flag. If it coincides with a new underrun event, set wins.
- Clamp: x = hold limited to [-LIMIT, +LIMIT], then sign-extended to ACC_WIDTH.
- Modulator (each clock with run=1):
  - fb = sdo ? +FS : -FS.
  - i1n = sat(i1 + x - fb); i2n = sat(i2 + i1n - fb).
  - sat clamps to ±(2**(ACC_WIDTH-1)-1).
  - i1<=i1n; i2<=i2n; sdo<=(i2n>=0).
  - Long-run mean of sdo mapped to ±1 equals x/FS.
- Latency: a sample held in buf reaches hold on the next hit and first influences sdo 2 clocks after that hit.
- run=0:
  - i1, i2 and cnt forced to 0, and frame=0.
  - sdo toggles every clock, giving an idle pattern with zero mean.
  - hold is kept; the buffer still accepts one sample.
  - run rising: counting starts at cnt=0, so the first hit occurs osr_reg clocks later.
- Arithmetic: all signed two's complement. Internal sums are computed at ACC_WIDTH+2 bits before saturation.

Test Plan:
- Reset: aclr pulse mid-frame with the buffer full -> next cycle sdo=0, ready=1, underrun=0, frame=0. Integrators read 0 via probe.
- DC zero: run=1, osr=255, data=0 every frame -> sdo ones count over 256 clocks in a steady frame is 128±2, with no underrun.
- DC +0.5 FS: data=16384, osr=255 -> ones count per steady frame is 192±3. Repeat with data=-16384 -> 64±3.
- Clamp: data=32767 -> treated as 24576, ones count per frame 224±3. The bitstream never sticks at 1 for more than 16 clocks.
- Underrun/handshake: feed one sample, then hold valid=0 across 2 boundaries -> underrun=1 after the first empty hit and hold unchanged. clr_underrun -> 0. ready=1 on the hit cycle while the buffer is full.
- OSR change: osr 255->15 mid-frame -> current frame still 256 clocks, following frames 16 clocks. frame pulse period is checked each time.
